uart_frame_scheduler: RTL and testbench
=======================================

// Module: uart_frame_scheduler
// PURPOSE
//  Shares the single UART TX byte path to the MCU between NREQ on-board requesters.
//  Requesters include key events, a seg-display status echo and IIC readback.
//  Arbitrates round-robin, latches the winning request and serialises it as one framed packet:
//    HDR, ID, LEN, payload, CHK
//  Sits between the requesters and the UART byte transmitter, which runs at BAUD_RATE 115_200 on sys_clk.
// PARAMETERS
//  NREQ      4     number of requesters (2..8)
//  MAX_LEN   4     max payload bytes per frame (1..4)
//  HDR_BYTE  8'hA5 frame start byte
//  GAP_CYC   16    idle sys_clk cycles enforced between frames (0 = none)
// PORTS
//  sys_clk     in   1          system clock
//  sys_rst     in   1          synchronous active-high reset
//  req         in   NREQ       level request; requester i holds it until req_ack[i]
//  req_data    in   NREQ*32    payload of requester i at [32i+31:32i]; byte0 = [7:0] is sent first
//  req_len     in   NREQ*3     payload length of requester i, bytes
//  req_ack     out  NREQ       1-cycle pulse: request i latched; requester may change data/deassert
//  tx_data     out  8          byte to transmitter
//  tx_valid    out  1          byte valid; held with tx_data stable until tx_ready
//  tx_ready    in   1          transmitter can take a byte; transfer = tx_valid & tx_ready
//  busy        out  1          high from grant until the CHK byte transfers (GAP excluded)
//  frame_cnt   out  16         count of completed frames; wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset (sys_rst=1 at posedge):
//   - state=IDLE; req_ack=0, tx_valid=0, tx_data=0, busy=0, frame_cnt=0
//   - rr pointer=0; gap counter=0
//   - Reset mid-frame abandons the frame immediately, with no CHK sent.
//  FSM states: IDLE -> GRANT -> HDR -> ID -> LEN -> PAY -> CHK -> GAP -> IDLE
//   - IDLE: if |req, go to GRANT next cycle.
//   - GRANT (1 cycle): pick first set req at index >= rr_ptr, wrapping modulo NREQ.
//     - Latch id, data and len_eff; pulse req_ack[id].
//     - Set rr_ptr = id+1 (mod NREQ); busy goes 1.
//   - HDR/ID/LEN/PAY/CHK: drive tx_valid=1 with the state's byte; advance only on tx_valid & tx_ready.
//     - ID byte  = {5'b0,id}
//     - LEN byte = {5'b0,len_eff}
//     - PAY sends bytes 0..len_eff-1 of the latched data.
//     - If len_eff=0, LEN goes directly to CHK.
//   - CHK byte = (id + len_eff + sum of payload bytes) mod 256. HDR is excluded from the sum.
//   - After the CHK transfer:
//     - frame_cnt+1 and busy=0.
//     - Enter GAP for GAP_CYC cycles with tx_valid=0, then go to IDLE.
//     - If GAP_CYC=0, skip GAP and go directly to IDLE.
//  Rules:
//   - len_eff = min(req_len, MAX_LEN); values above MAX_LEN are clamped, never an error.
//   - tx_valid never drops and tx_data never changes while tx_valid=1 & tx_ready=0.
//   - Minimum latency: req rising in IDLE -> req_ack at +1 cycle -> HDR tx_valid at +2 cycles.
//   - req changes after latching do not affect the frame in flight.
//   - A req deasserted before grant is not served.
//   - A requester that re-asserts while its frame is in flight is queued normally.
//   - Simultaneous requests are resolved by rr_ptr only; there is no fixed priority.
//   - Any requester is served within NREQ frames.
//   - req_ack is one-hot or zero; exactly one pulse per frame.
// STRUCTURE
//  - Shared package uart_frame_pkg holds:
//    - state enum (IDLE, GRANT, HDR, ID, LEN, PAY, CHK, GAP)
//    - HDR default and width localparams (ID_W = clog2(NREQ), LEN_W = 3)
//  - One sub-module, rr_arbiter (req, rr_ptr -> gnt_id, gnt_vld), combinational, reused by the IIC arbiter.
//  - Byte mux, checksum accumulator and counters stay in this module.
// TESTING
//  1. Single request:
//     - Stimulus: req=4'b0010, req_len[1]=3, data=32'h0033_2211, tx_ready=1.
//     - Required: bytes A5,01,03,11,22,33,6A; req_ack[1] one pulse; frame_cnt=1.
//  2. Contention:
//     - Stimulus: req=4'b1111 held, all len=1.
//     - Required: grant order 0,1,2,3,0; each frame separated by exactly 16 idle cycles.
//  3. Backpressure:
//     - Stimulus: tx_ready toggles 1/0 every cycle and is held 0 for 50 cycles during PAY.
//     - Required: no byte lost or duplicated; tx_data stable while stalled.
//  4. Length edges:
//     - Stimulus: req_len=0 with id=2.
//     - Required: A5,02,00,02.
//     - Stimulus: req_len=7, MAX_LEN=4.
//     - Required: LEN byte=04 and 4 payload bytes.
//  5. Reset mid-frame:
//     - Stimulus: sys_rst=1 for 1 cycle during PAY.
//     - Required: tx_valid=0 next cycle; busy=0; next grant starts from requester 0.
//  6. Counter wrap:
//     - Stimulus: force frame_cnt=16'hFFFF, then complete one frame.
//     - Required: frame_cnt=0.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame scheduler and its round-robin arbiter.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StHdr,
        StId,
        StLen,
        StPay,
        StChk,
        StGap
    } frame_state_e;

    localparam logic [7:0]  HDR_DEFAULT = 8'hA5;
    // ID field is sized for the largest supported requester count (8).
    localparam int unsigned ID_W        = 3;
    localparam int unsigned LEN_W       = 3;

    function automatic logic [LEN_W-1:0] clamp_len(logic [LEN_W-1:0] len, int unsigned max_len);
        return (32'(len) > max_len) ? LEN_W'(max_len) : len;
    endfunction

endpackage

// File: rtl/uart_frame_scheduler_if.sv
// Requester-side and transmitter-side handshake bundle of the UART frame scheduler.
interface uart_frame_scheduler_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ*3-1:0]  req_len;
    logic [NREQ-1:0]    req_ack;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;

    modport master (
        input  req, req_data, req_len, tx_ready,
        output req_ack, tx_data, tx_valid
    );

    modport slave (
        output req, req_data, req_len, tx_ready,
        input  req_ack, tx_data, tx_valid
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping modulo NREQ.
module rr_arbiter
    import uart_frame_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_vld
);

    always_comb begin
        gnt_id  = '0;
        gnt_vld = 1'b0;
        // Walk offsets from farthest to nearest so the nearest set request wins.
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_ptr) + k) % int'(NREQ);
            if (req[idx]) begin
                gnt_id  = ID_W'(idx);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Shares one UART TX byte path between NREQ requesters: round-robin grant, then one packet
// HDR, ID, LEN, payload, CHK per granted request, followed by an idle gap.
module uart_frame_scheduler
    import uart_frame_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MAX_LEN  = 4,
    parameter logic [7:0]  HDR_BYTE = HDR_DEFAULT,
    parameter int unsigned GAP_CYC  = 16
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    uart_frame_scheduler_if.master bus,
    output logic                   busy,
    output logic [15:0]            frame_cnt
);

    localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

    frame_state_e     state_q, state_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [31:0]      data_q, data_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [7:0]       chk_q, chk_d;
    logic [15:0]      gap_q, gap_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    logic [ID_W-1:0]  gnt_id;
    logic             gnt_vld;
    logic [LEN_W-1:0] grant_len;
    logic [7:0]       pay_byte;
    logic [NREQ-1:0]  req_ack;
    logic [7:0]       tx_data;
    logic             tx_valid;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req     (bus.req),
        .rr_ptr  (rr_ptr_q),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld)
    );

    assign grant_len = clamp_len(bus.req_len[LEN_W*gnt_id +: LEN_W], MAX_LEN);
    assign pay_byte  = data_q[8*idx_q +: 8];

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        rr_ptr_d    = rr_ptr_q;
        data_d      = data_q;
        len_d       = len_q;
        idx_d       = idx_q;
        chk_d       = chk_q;
        gap_d       = gap_q;
        frame_cnt_d = frame_cnt_q;
        req_ack     = '0;
        tx_data     = 8'h00;
        tx_valid    = 1'b0;
        busy        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|bus.req) state_d = StGrant;
            end
            StGrant: begin
                // A request dropped before this cycle is simply not served.
                if (gnt_vld) begin
                    busy     = 1'b1;
                    req_ack  = NREQ'(1) << gnt_id;
                    id_d     = gnt_id;
                    data_d   = bus.req_data[32*gnt_id +: 32];
                    len_d    = grant_len;
                    idx_d    = '0;
                    chk_d    = 8'(gnt_id) + 8'(grant_len);
                    rr_ptr_d = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + ID_W'(1);
                    state_d  = StHdr;
                end else begin
                    state_d = StIdle;
                end
            end
            StHdr: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = HDR_BYTE;
                if (bus.tx_ready) state_d = StId;
            end
            StId: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = {{(8-ID_W){1'b0}}, id_q};
                if (bus.tx_ready) state_d = StLen;
            end
            StLen: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = {{(8-LEN_W){1'b0}}, len_q};
                if (bus.tx_ready) state_d = (len_q == '0) ? StChk : StPay;
            end
            StPay: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = pay_byte;
                if (bus.tx_ready) begin
                    chk_d = chk_q + pay_byte;
                    idx_d = idx_q + LEN_W'(1);
                    if ((idx_q + LEN_W'(1)) == len_q) state_d = StChk;
                end
            end
            StChk: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_data  = chk_q;
                if (bus.tx_ready) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    gap_d       = '0;
                    state_d     = (GAP_CYC == 0) ? StIdle : StGap;
                end
            end
            StGap: begin
                if (gap_q == GAP_LAST) state_d = StIdle;
                else                   gap_d   = gap_q + 16'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= StIdle;
            id_q        <= '0;
            rr_ptr_q    <= '0;
            data_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            chk_q       <= '0;
            gap_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            rr_ptr_q    <= rr_ptr_d;
            data_q      <= data_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            chk_q       <= chk_d;
            gap_q       <= gap_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.req_ack  = req_ack;
    assign bus.tx_data  = tx_data;
    assign bus.tx_valid = tx_valid;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Self-checking bench for uart_frame_scheduler: vector table, directed corner cases and
// randomized traffic scored against a frame-level reference model.
module tb_uart_frame_scheduler;
    import uart_frame_pkg::*;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned GAP_CYC = 16;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        busy;
    logic [15:0] frame_cnt;

    uart_frame_scheduler_if #(.NREQ(NREQ)) bus ();

    uart_frame_scheduler #(
        .NREQ     (NREQ),
        .MAX_LEN  (MAX_LEN),
        .HDR_BYTE (8'hA5),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .bus       (bus),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Stimulus state owned by the bench
    logic [31:0] cur_data [NREQ];
    logic [2:0]  cur_len  [NREQ];
    bit          hold_req    = 1'b0;
    int          ready_mode  = 0;
    int          stall_left  = 0;

    // Monitor / scoreboard state
    logic [7:0]      exp_q[$];
    logic [7:0]      cur_frame[$];
    logic [7:0]      last_frame[$];
    int              ack_hist[$];
    int              gap_runs[$];
    int              cyc = 0, frames_done = 0, model_ptr = 0;
    int              last_ack_id = -1, ack_cyc = -1, rise_cyc = -1, idle_run = 0;
    bit              gap_track = 1'b0, gap_armed = 1'b0;
    logic [NREQ-1:0] last_ack = '0;
    logic            prev_stall = 1'b0, prev_valid = 1'b0;
    logic [7:0]      prev_data = '0;

    // Round-robin rule: first pending requester at or after ptr, wrapping.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 0; k < int'(NREQ); k++) begin
            if (r[(ptr + k) % int'(NREQ)]) return (ptr + k) % int'(NREQ);
        end
        return -1;
    endfunction

    function automatic void push_frame(input int id);
        int len_eff;
        int sum;
        len_eff = (int'(cur_len[id]) > int'(MAX_LEN)) ? int'(MAX_LEN) : int'(cur_len[id]);
        sum = id + len_eff;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(id));
        exp_q.push_back(8'(len_eff));
        for (int b = 0; b < len_eff; b++) begin
            exp_q.push_back(cur_data[id][8*b +: 8]);
            sum += int'(cur_data[id][8*b +: 8]);
        end
        exp_q.push_back(8'(sum));
    endfunction

    function automatic logic [7:0] frame_byte(input int idx);
        if (idx >= 0 && idx < last_frame.size()) return last_frame[idx];
        return 8'hxx;
    endfunction

    always @(negedge sys_clk) begin
        cyc++;
        if (sys_rst) begin
            exp_q.delete();
            cur_frame.delete();
            model_ptr  = 0;
            prev_stall = 1'b0;
            prev_valid = 1'b0;
            last_ack   = '0;
            idle_run   = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(bus.tx_valid), 32'd1);
                check("stall_data", 32'(bus.tx_data), 32'(prev_data));
            end
            if (bus.req_ack != '0) begin
                int exp_id;
                exp_id = rr_pick(bus.req, model_ptr);
                check("ack_onehot", 32'($onehot(bus.req_ack)), 32'd1);
                check("ack_id", 32'(bus.req_ack), (exp_id < 0) ? 32'd0 : (32'd1 << exp_id));
                if (exp_id >= 0) begin
                    model_ptr = (exp_id + 1) % int'(NREQ);
                    push_frame(exp_id);
                    ack_hist.push_back(exp_id);
                    last_ack_id = exp_id;
                    ack_cyc     = cyc;
                end
            end
            last_ack = bus.req_ack;
            if (bus.tx_valid) check("busy_in_frame", 32'(busy), 32'd1);
            if (bus.tx_valid && !prev_valid) rise_cyc = cyc;
            if (gap_track) begin
                if (!bus.tx_valid) idle_run++;
                else begin
                    if (idle_run > 0 && gap_armed) gap_runs.push_back(idle_run);
                    idle_run  = 0;
                    gap_armed = 1'b1;
                end
            end
            if (bus.tx_valid && bus.tx_ready) begin
                check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
                    cur_frame.push_back(bus.tx_data);
                    if (exp_q.size() == 0) begin
                        frames_done++;
                        last_frame = cur_frame;
                        cur_frame.delete();
                    end
                end
            end
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
            prev_valid = bus.tx_valid;
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
        if (!hold_req) bus.req = bus.req & ~last_ack;
        case (ready_mode)
            0:       bus.tx_ready = 1'b1;
            1:       bus.tx_ready = ~bus.tx_ready;
            default: bus.tx_ready = 1'($urandom_range(0, 1));
        endcase
        if (stall_left > 0) begin
            bus.tx_ready = 1'b0;
            stall_left--;
        end
    endtask

    task automatic set_req(input int id, input logic [2:0] len, input logic [31:0] data);
        cur_data[id]             = data;
        cur_len[id]              = len;
        bus.req_data[32*id +: 32] = data;
        bus.req_len[3*id +: 3]    = len;
        bus.req[id]               = 1'b1;
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int i;
        i = 0;
        while (frames_done < target && i < budget) begin
            step();
            i++;
        end
        check(name, 32'(frames_done), 32'(target));
    endtask

    task automatic settle();
        for (int i = 0; i < int'(GAP_CYC) + 4; i++) step();
    endtask

    typedef struct {
        int          id;
        logic [2:0]  len;
        logic [31:0] data;
        logic [7:0]  exp_len;
        logic [7:0]  exp_chk;
        int          exp_n;
    } vec_t;

    vec_t vecs[6];
    logic [7:0] single_exp[7];

    initial begin
        int wrap_base;
        int i;

        vecs[0] = '{2, 3'd0, 32'hDEAD_BEEF, 8'h00, 8'h02, 4};
        vecs[1] = '{0, 3'd7, 32'h4433_2211, 8'h04, 8'hAE, 8};
        vecs[2] = '{1, 3'd5, 32'h0102_0304, 8'h04, 8'h0F, 8};
        vecs[3] = '{0, 3'd2, 32'h0000_FFFE, 8'h02, 8'hFF, 6};
        vecs[4] = '{3, 3'd1, 32'h1234_56FF, 8'h01, 8'h03, 5};
        vecs[5] = '{3, 3'd4, 32'h8080_8080, 8'h04, 8'h07, 8};
        single_exp = '{8'hA5, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};

        for (int r = 0; r < int'(NREQ); r++) begin
            cur_data[r] = '0;
            cur_len[r]  = '0;
        end
        sys_rst      = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_len  = '0;
        bus.tx_ready = 1'b0;
        step();
        step();
        @(negedge sys_clk);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_req_ack", 32'(bus.req_ack), 32'd0);
        step();
        sys_rst = 1'b0;
        step();

        // Single request with minimum-latency check
        begin
            int t0;
            t0 = cyc + 1;
            set_req(1, 3'd3, 32'h0033_2211);
            wait_frames(1, 200, "single_done");
            check("single_ack_lat", 32'(ack_cyc), 32'(t0 + 1));
            check("single_hdr_lat", 32'(rise_cyc), 32'(t0 + 2));
            check("single_nbytes", 32'(last_frame.size()), 32'd7);
            for (int b = 0; b < 7; b++) check("single_byte", 32'(frame_byte(b)), 32'(single_exp[b]));
            check("single_ack_id", 32'(last_ack_id), 32'd1);
            check("single_frame_cnt", 32'(frame_cnt), 32'd1);
        end
        settle();
        check("idle_busy", 32'(busy), 32'd0);

        // Vector table: one requester at a time
        foreach (vecs[v]) begin
            set_req(vecs[v].id, vecs[v].len, vecs[v].data);
            wait_frames(frames_done + 1, 300, "vec_done");
            check("vec_nbytes", 32'(last_frame.size()), 32'(vecs[v].exp_n));
            check("vec_id", 32'(frame_byte(1)), 32'(vecs[v].id));
            check("vec_len", 32'(frame_byte(2)), 32'(vecs[v].exp_len));
            check("vec_chk", 32'(frame_byte(vecs[v].exp_n - 1)), 32'(vecs[v].exp_chk));
        end
        settle();

        // Contention: all four held, len 1
        ack_hist.delete();
        gap_runs.delete();
        idle_run  = 0;
        gap_armed = 1'b0;
        gap_track = 1'b1;
        hold_req  = 1'b1;
        for (int r = 0; r < int'(NREQ); r++) set_req(r, 3'd1, $urandom);
        wait_frames(frames_done + 5, 600, "cont_done");
        hold_req  = 1'b0;
        bus.req   = '0;
        gap_track = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("cont_order", (k < ack_hist.size()) ? 32'(ack_hist[k]) : 32'hFFFF, 32'(k % 4));
        end
        check("cont_ngaps", 32'(gap_runs.size()), 32'd4);
        // tx_valid-low run between frames: GAP cycles plus the IDLE and GRANT cycles
        foreach (gap_runs[g]) check("cont_gap", 32'(gap_runs[g]), 32'(GAP_CYC + 2));
        settle();

        // Backpressure: toggling ready plus a long stall inside the payload
        ready_mode = 1;
        set_req(2, 3'd4, $urandom);
        i = 0;
        while (cur_frame.size() < 4 && i < 100) begin
            step();
            i++;
        end
        check("bp_reached_pay", 32'(cur_frame.size() >= 4), 32'd1);
        stall_left = 50;
        wait_frames(frames_done + 1, 300, "bp_done");
        check("bp_nbytes", 32'(last_frame.size()), 32'd8);
        ready_mode = 0;
        settle();

        // Reset in the middle of a payload; rr pointer returns to 0
        set_req(2, 3'd4, $urandom);
        i = 0;
        while (cur_frame.size() < 4 && i < 100) begin
            step();
            i++;
        end
        check("rst_reached_pay", 32'(cur_frame.size() >= 4), 32'd1);
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        step();
        bus.req = '0;
        set_req(3, 3'd1, $urandom);
        set_req(0, 3'd2, $urandom);
        wait_frames(frames_done + 1, 300, "midrst_f1");
        check("midrst_first_id", 32'(last_ack_id), 32'd0);
        wait_frames(frames_done + 1, 300, "midrst_f2");
        check("midrst_second_id", 32'(last_ack_id), 32'd3);
        check("midrst_frame_cnt", 32'(frame_cnt), 32'd2);
        settle();

        // Frame counter wrap
        force dut.frame_cnt_q = 16'hFFFF;
        step();
        step();
        release dut.frame_cnt_q;
        check("wrap_preload", 32'(frame_cnt), 32'hFFFF);
        set_req(1, 3'd2, $urandom);
        wait_frames(frames_done + 1, 300, "wrap_done");
        check("wrap_frame_cnt", 32'(frame_cnt), 32'd0);
        wrap_base = frames_done;
        settle();

        // Randomized traffic
        ready_mode = 2;
        for (int c = 0; c < 1500; c++) begin
            step();
            for (int r = 0; r < int'(NREQ); r++) begin
                if (!bus.req[r] && $urandom_range(0, 7) == 0) set_req(r, 3'($urandom_range(0, 7)), $urandom);
            end
        end
        i = 0;
        while ((bus.req != '0 || exp_q.size() != 0 || busy) && i < 3000) begin
            step();
            i++;
        end
        check("rand_drained", 32'(bus.req == '0 && exp_q.size() == 0 && !busy), 32'd1);
        check("rand_frame_cnt", 32'(frame_cnt), 32'(16'(frames_done - wrap_base)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d cycles, required completion", cyc);
        $fatal(1);
    end

endmodule
